// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: control word bit positions, the inactive
// control word and the program loader state encoding.
package cpu_pkg;

  localparam int CW_CP   = 14;
  localparam int CW_EP   = 13;
  localparam int CW_LP   = 12;
  localparam int CW_NLMA = 11;
  localparam int CW_NLMD = 10;
  localparam int CW_NCE  = 9;
  localparam int CW_NLR  = 8;
  localparam int CW_NLI  = 7;
  localparam int CW_NEI  = 6;
  localparam int CW_NLA  = 5;
  localparam int CW_EA   = 4;
  localparam int CW_SUB  = 3;
  localparam int CW_EU   = 2;
  localparam int CW_NLB  = 1;
  localparam int CW_NLO  = 0;

  // Active-high strobes low, active-low strobes high: nothing happens on the datapath.
  localparam logic [14:0] IDLE_CW = 15'h0FE3;

  typedef enum logic [2:0] {
    L_IDLE  = 3'd0,
    L_ADDR  = 3'd1,
    L_DATA  = 3'd2,
    L_WRITE = 3'd3,
    L_NEXT  = 3'd4,
    RUN     = 3'd5
  } loader_state_e;

endpackage

// File: rtl/program_loader.sv
// Program loader: owns the CPU while load_req is high and sequences host bytes into
// MAR/RAM over the shared bus; otherwise passes the control word through and releases reset.
module program_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int CW_W   = 15,
  parameter logic [CW_W-1:0] IDLE_CW = cpu_pkg::IDLE_CW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              host_valid,
  input  logic              host_cmd,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ready,
  input  logic [CW_W-1:0]   cw_in,
  output logic [CW_W-1:0]   cw_out,
  output logic              bus_drive,
  output logic [DATA_W-1:0] bus_data,
  output logic              cpu_rst_n,
  output logic [ADDR_W-1:0] load_addr,
  output logic              wrapped,
  output logic [2:0]        dbg_state
);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] byte_q, byte_d;
  logic              wrapped_q, wrapped_d;
  logic [ADDR_W-1:0] addr_inc;
  logic              accept;

  // Host handshake: a byte transfers in a cycle where host_valid && host_ready;
  // host_ready is high only in L_IDLE, so the host must hold its byte until then.
  assign accept   = host_valid && (state_q == L_IDLE);
  assign addr_inc = addr_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= L_IDLE;
      addr_q    <= '0;
      byte_q    <= '0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      byte_q    <= byte_d;
      wrapped_q <= wrapped_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    byte_d    = byte_q;
    wrapped_d = wrapped_q;
    case (state_q)
      L_IDLE: begin
        if (accept) begin
          if (!host_cmd) begin
            addr_d    = host_data[ADDR_W-1:0];
            wrapped_d = 1'b0;
            state_d   = L_ADDR;
          end else begin
            byte_d  = host_data;
            state_d = L_DATA;
          end
        end else if (!load_req) begin
          state_d = RUN;
        end
      end
      L_ADDR:  state_d = L_IDLE;
      L_DATA:  state_d = L_WRITE;
      L_WRITE: state_d = L_NEXT;
      L_NEXT: begin
        addr_d = addr_inc;
        if (addr_q == {ADDR_W{1'b1}}) wrapped_d = 1'b1;
        state_d = L_IDLE;
      end
      RUN: begin
        if (load_req) state_d = L_IDLE;
      end
      default: state_d = L_IDLE;
    endcase
  end

  // Moore decode of the state register; only RUN forwards cw_in combinationally.
  always_comb begin
    cw_out     = IDLE_CW;
    bus_drive  = 1'b0;
    bus_data   = '0;
    host_ready = 1'b0;
    cpu_rst_n  = 1'b0;
    case (state_q)
      L_IDLE: host_ready = 1'b1;
      L_ADDR: begin
        bus_drive       = 1'b1;
        bus_data        = DATA_W'(addr_q);
        cw_out[CW_NLMA] = 1'b0;
      end
      L_DATA: begin
        bus_drive       = 1'b1;
        bus_data        = byte_q;
        cw_out[CW_NLMD] = 1'b0;
      end
      L_WRITE: cw_out[CW_NLR] = 1'b0;
      L_NEXT: begin
        bus_drive       = 1'b1;
        bus_data        = DATA_W'(addr_inc);
        cw_out[CW_NLMA] = 1'b0;
      end
      RUN: begin
        cw_out    = cw_in;
        cpu_rst_n = 1'b1;
      end
      default: ;
    endcase
  end

  assign load_addr = addr_q;
  assign wrapped   = wrapped_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a transaction-level expectation queue checked every
// cycle, a MAR/RAM environment fed by the loader's bus, and literal spot checks.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_req;
  logic        host_valid;
  logic        host_cmd;
  logic [7:0]  host_data;
  logic        host_ready;
  logic [14:0] cw_in;
  logic [14:0] cw_out;
  logic        bus_drive;
  logic [7:0]  bus_data;
  logic        cpu_rst_n;
  logic [3:0]  load_addr;
  logic        wrapped;
  logic [2:0]  dbg_state;

  localparam logic [14:0] CW_IDLE = 15'h0FE3;
  localparam logic [14:0] M_NLMA  = 15'h0800;
  localparam logic [14:0] M_NLMD  = 15'h0400;
  localparam logic [14:0] M_NLR   = 15'h0100;

  int checks = 0;
  int errors = 0;

  program_loader dut (
    .clk(clk), .rst(rst), .load_req(load_req), .host_valid(host_valid),
    .host_cmd(host_cmd), .host_data(host_data), .host_ready(host_ready),
    .cw_in(cw_in), .cw_out(cw_out), .bus_drive(bus_drive), .bus_data(bus_data),
    .cpu_rst_n(cpu_rst_n), .load_addr(load_addr), .wrapped(wrapped),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- environment: MAR + RAM on the shared bus ----------------
  logic [3:0] env_mar = 4'd0;
  logic [7:0] env_mdr = 8'd0;
  logic [7:0] env_ram [16];
  int         cyc = 0;
  int         nlr_q[$];

  initial for (int i = 0; i < 16; i++) env_ram[i] = 8'h00;

  always @(posedge clk) begin
    cyc++;
    if (cpu_rst_n === 1'b0) begin
      if (cw_out[11] === 1'b0) env_mar <= bus_data[3:0];
      if (cw_out[10] === 1'b0) env_mdr <= bus_data;
      if (cw_out[8] === 1'b0) begin
        env_ram[env_mar] <= env_mdr;
        nlr_q.push_back(cyc);
      end
    end
  end

  // ---------------- behavioural model + scoreboard ----------------
  typedef struct packed {
    logic [14:0] cw;
    logic        drive;
    logic [7:0]  data;
    logic [3:0]  addr;
    logic        wrapped;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  logic       busy;
  bit         mdl_valid = 0;
  bit         mdl_run   = 0;
  int         mdl_addr  = 0;
  bit         mdl_wrapped = 0;
  logic [7:0] mdl_ram [16];

  initial for (int i = 0; i < 16; i++) mdl_ram[i] = 8'h00;

  always @(negedge clk) begin
    busy = 1'b0;
    if (mdl_valid) begin
      if (exp_q.size() > 0) begin
        e    = exp_q.pop_front();
        busy = 1'b1;
      end else begin
        e.cw      = mdl_run ? cw_in : CW_IDLE;
        e.drive   = 1'b0;
        e.data    = 8'h00;
        e.addr    = 4'(mdl_addr);
        e.wrapped = mdl_wrapped;
      end
      chk("cw_out",     32'(cw_out),     32'(e.cw));
      chk("bus_drive",  32'(bus_drive),  32'(e.drive));
      chk("bus_data",   32'(bus_data),   32'(e.data));
      chk("load_addr",  32'(load_addr),  32'(e.addr));
      chk("wrapped",    32'(wrapped),    32'(e.wrapped));
      chk("host_ready", 32'(host_ready), 32'(!busy && !mdl_run));
      chk("cpu_rst_n",  32'(cpu_rst_n),  32'(!busy && mdl_run));
    end
    if (rst) begin
      exp_q.delete();
      mdl_addr    = 0;
      mdl_wrapped = 0;
      mdl_run     = 0;
      mdl_valid   = 1;
    end else if (mdl_valid && !busy) begin
      if (mdl_run) begin
        if (load_req) mdl_run = 0;
      end else if (host_valid) begin
        if (!host_cmd) begin
          mdl_addr    = int'(host_data[3:0]);
          mdl_wrapped = 0;
          exp_q.push_back('{CW_IDLE & ~M_NLMA, 1'b1, {4'h0, host_data[3:0]}, host_data[3:0], 1'b0});
        end else begin
          exp_q.push_back('{CW_IDLE & ~M_NLMD, 1'b1, host_data, 4'(mdl_addr), mdl_wrapped});
          exp_q.push_back('{CW_IDLE & ~M_NLR, 1'b0, 8'h00, 4'(mdl_addr), mdl_wrapped});
          exp_q.push_back('{CW_IDLE & ~M_NLMA, 1'b1, 8'((mdl_addr + 1) % 16), 4'(mdl_addr), mdl_wrapped});
          mdl_ram[mdl_addr] = host_data;
          if (mdl_addr == 15) mdl_wrapped = 1;
          mdl_addr = (mdl_addr + 1) % 16;
        end
      end else if (!load_req) begin
        mdl_run = 1;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic cmd, input logic [7:0] data);
    bit ok = 0;
    host_cmd   = cmd;
    host_data  = data;
    host_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (host_ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: host_ready never rose for byte %0h", data);
    end
    @(posedge clk);
    #1;
    host_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst        = 1'b1;
    load_req   = 1'b1;
    host_valid = 1'b0;
    host_cmd   = 1'b0;
    host_data  = 8'h00;
    cw_in      = CW_IDLE;
    step(2);
    rst = 1'b0;

    // loader holds the CPU with no host traffic
    step(5);
    @(negedge clk);
    chk("idle_cw",        32'(cw_out),     32'h0FE3);
    chk("idle_cpu_rst_n", 32'(cpu_rst_n),  32'h0);
    chk("idle_ready",     32'(host_ready), 32'h1);
    chk("idle_addr",      32'(load_addr),  32'h0);

    // address byte, upper nibble ignored
    send(1'b0, 8'hA5);
    @(negedge clk);
    chk("addr_bus_data", 32'(bus_data),   32'h05);
    chk("addr_nlma",     32'(cw_out[11]), 32'h0);
    chk("addr_latched",  32'(load_addr),  32'h5);
    step(1);
    @(negedge clk);
    chk("addr_ready_back", 32'(host_ready), 32'h1);

    // address 14 then three data bytes back-to-back across the wrap
    send(1'b0, 8'h0E);
    nlr_q.delete();
    send(1'b1, 8'h3C);
    send(1'b1, 8'h7E);
    send(1'b1, 8'h11);
    step(5);
    chk("ram14",       32'(env_ram[14]), 32'h3C);
    chk("ram15",       32'(env_ram[15]), 32'h7E);
    chk("ram0",        32'(env_ram[0]),  32'h11);
    chk("wrap_sticky", 32'(wrapped),     32'h1);
    chk("nlr_pulses",  32'(nlr_q.size()), 32'd3);
    if (nlr_q.size() == 3) begin
      chk("nlr_gap0", 32'(nlr_q[1] - nlr_q[0]), 32'd4);
      chk("nlr_gap1", 32'(nlr_q[2] - nlr_q[1]), 32'd4);
    end

    // load_req dropped mid-sequence: write completes, then RUN
    send(1'b1, 8'h9A);
    load_req = 1'b0;
    step(4);
    @(negedge clk);
    chk("run_cpu_rst_n", 32'(cpu_rst_n), 32'h1);
    chk("run_ram1",      32'(env_ram[1]), 32'h9A);
    cw_in = 15'h2A5A;
    @(negedge clk);
    chk("run_cw_pass_a", 32'(cw_out), 32'h2A5A);
    cw_in = 15'h1234;
    #1;
    chk("run_cw_pass_b", 32'(cw_out), 32'h1234);

    // host traffic in RUN is ignored
    host_cmd   = 1'b1;
    host_data  = 8'hFF;
    host_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("run_ready_low", 32'(host_ready), 32'h0);
      chk("run_bus_off",   32'(bus_drive),  32'h0);
    end
    step(1);
    host_valid = 1'b0;
    cw_in      = CW_IDLE;
    load_req   = 1'b1;
    step(1);
    @(negedge clk);
    chk("reload_cpu_rst_n", 32'(cpu_rst_n), 32'h0);
    chk("reload_ready",     32'(host_ready), 32'h1);

    // synchronous reset while in L_WRITE
    send(1'b1, 8'h55);
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_nlr_high", 32'(cw_out[8]), 32'h1);
    chk("rst_cw",       32'(cw_out),    32'h0FE3);
    chk("rst_addr",     32'(load_addr), 32'h0);
    chk("rst_wrapped",  32'(wrapped),   32'h0);

    step(3);
    for (int i = 0; i < 16; i++) chk($sformatf("ram_final[%0d]", i), 32'(env_ram[i]), 32'(mdl_ram[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
